melodia_alarma: RTL
===================

Name: melodia_alarma

Overview:
- Programmable multi-note square-wave melody player for buzzer/alarm output; successor to the fixed single-melody alarm.
- Note table (half-period, duration) is written at run time. The melody plays N times with a silent pause between plays.
- Supports an octave-down mode (half-period ×2) and rest notes.
- Sits between the plant-status control logic (start/stop, write port) and the buzzer pin.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency; documentation and package constants only.
- N_NOTES, 16, note table depth (power of two).
- HP_W, 20, half-period field width in clocks.
- DUR_W, 28, note duration field width in clocks.
- PAUSE_W, 28, width of the inter-play pause count.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  note table write strobe.
- wr_addr  in  $clog2(N_NOTES)  table write address.
- wr_half_period  in  HP_W  clocks per output half-cycle; 0 = rest (silence).
- wr_duration  in  DUR_W  note length in clocks; 0 = skip note.
- num_notes  in  $clog2(N_NOTES)+1  notes per play, 1..N_NOTES; sampled at start.
- repeats  in  4  plays per start; 0 = loop until stop; sampled at start.
- pause_len  in  PAUSE_W  silent clocks between plays; sampled at start.
- octave_down  in  1  1 = every half-period doubled; sampled at each note load.
- start  in  1  begin playback (level or pulse; acted on only in IDLE).
- stop  in  1  abort playback.
- salida  out  1  square-wave buzzer drive.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse on natural completion.
- note_idx  out  $clog2(N_NOTES)  index of the current note.

Behaviour:
- Reset: all state returns to IDLE. salida=0, busy=0, done=0, note_idx=0, all counters 0. Table contents are not reset.
- Table: synchronous write on wr_en, legal in any state. A write to the note currently playing takes effect at its next load.
- States: IDLE, LOAD, TONE, PAUSE.
- IDLE:
  - start=1 → LOAD on the next cycle.
  - Latch num_notes (0 is treated as 1; values >N_NOTES clamp to N_NOTES), repeats and pause_len.
  - Set note_idx=0 and play_cnt=0.
- LOAD (1 cycle):
  - Fetch entry[note_idx] and compute hp_eff = octave_down ? hp<<1 : hp, one bit wider than HP_W.
  - Clear the tone and duration counters; force salida=0.
  - duration==0 → advance immediately; otherwise → TONE.
- TONE:
  - dur_cnt increments every cycle.
  - hp_eff≠0: tone_cnt counts 0..hp_eff-1. When tone_cnt==hp_eff-1, toggle salida and clear tone_cnt.
  - hp_eff==0: salida held 0.
  - When dur_cnt==duration-1, advance.
  - The first edge of a note occurs exactly hp_eff cycles after entering TONE.
- Advance rule:
  - If note_idx<num_notes-1: note_idx++ → LOAD.
  - Else: play_cnt++. If repeats≠0 and play_cnt+1==repeats → IDLE with done=1 for 1 cycle. Otherwise note_idx=0 → PAUSE.
- PAUSE:
  - salida=0 for pause_len cycles, then → LOAD.
  - pause_len==0 → LOAD on the next cycle.
- stop (any non-IDLE state) → IDLE on the next cycle with salida=0. No done pulse. stop has priority over start and over any advance in the same cycle.
- start while busy: ignored.
- repeats==0: loops forever; done never asserts.
- Reset mid-note: output and state are immediately cleared (async).

Decomposition:
- Package melodia_pkg:
  - state enum;
  - note constants at 50 MHz: MI_HP=37_922, SI_HP=50_619, DO_HP=47_778, FA_HP=35_793, RE_HP=42_566;
  - duration helpers: MS_TO_CLK(ms) = ms*CLK_HZ/1000.
- Sub-module: tono_gen (hp_eff, enable, clear → salida), instantiated once.
- Note table stays inline as a small register-file RAM.

Test Plan:
- Reset during TONE at cycle 100 → salida=0, busy=0 immediately; stays IDLE after rst_n rises.
- Table {hp=4,dur=40},{hp=0,dur=10}, num_notes=2, repeats=1, start → note0 edges every 4 clocks (10 toggles); then 10 clocks of salida=0; done pulses once; busy falls.
- Same table with octave_down=1 → note0 edges every 8 clocks; 5 toggles in 40 clocks.
- num_notes=1 {hp=3,dur=12}, repeats=3, pause_len=20 → three 12-clock bursts separated by 20 quiet clocks (plus the LOAD cycle); done after the third burst only.
- repeats=0, stop asserted mid-note on the 5th play → IDLE next cycle, salida=0, no done.
- Entry with dur=0 in the middle of 3 notes → skipped (note_idx jumps 0→2 after one LOAD cycle); start while busy has no effect.

Source files
------------

// File: rtl/melodia_pkg.sv
// Shared types and constants for the melodia_alarma buzzer melody player.
// Note half-periods assume the 50 MHz system clock.
package melodia_pkg;

  localparam int CLK_HZ = 50_000_000;

  localparam int MI_HP = 37_922;
  localparam int SI_HP = 50_619;
  localparam int DO_HP = 47_778;
  localparam int FA_HP = 35_793;
  localparam int RE_HP = 42_566;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    TONE  = 2'd2,
    PAUSE = 2'd3
  } state_t;

  // Converts a duration in milliseconds to system clock cycles.
  function automatic longint unsigned MS_TO_CLK(input longint unsigned ms);
    return ms * 64'(CLK_HZ) / 64'd1000;
  endfunction

endpackage

// File: rtl/tono_gen.sv
// Square-wave generator: toggles its level every hp_eff enabled cycles.
// A zero half-period holds the output low (rest note).
module tono_gen #(
  parameter int HPE_W = 21
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [HPE_W-1:0] hp_eff,
  input  logic             enable,
  input  logic             clear,
  output logic             salida
);

  logic [HPE_W-1:0] tone_cnt;
  logic             level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tone_cnt <= '0;
      level    <= 1'b0;
    end else if (clear) begin
      tone_cnt <= '0;
      level    <= 1'b0;
    end else if (enable) begin
      if (hp_eff == '0) begin
        tone_cnt <= '0;
        level    <= 1'b0;
      end else if (tone_cnt == hp_eff - HPE_W'(1)) begin
        tone_cnt <= '0;
        level    <= ~level;
      end else begin
        tone_cnt <= tone_cnt + HPE_W'(1);
      end
    end
  end

  // Gating with enable drops the pin low the same cycle the note ends or is aborted.
  assign salida = level & enable;

endmodule

// File: rtl/melodia_alarma.sv
// Programmable multi-note alarm melody player with run-time note table,
// repeat count, inter-play pause and octave-down mode.
module melodia_alarma
  import melodia_pkg::*;
#(
  parameter int N_NOTES = 16,
  parameter int HP_W    = 20,
  parameter int DUR_W   = 28,
  parameter int PAUSE_W = 28
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [$clog2(N_NOTES)-1:0] wr_addr,
  input  logic [HP_W-1:0]            wr_half_period,
  input  logic [DUR_W-1:0]           wr_duration,
  input  logic [$clog2(N_NOTES):0]   num_notes,
  input  logic [3:0]                 repeats,
  input  logic [PAUSE_W-1:0]         pause_len,
  input  logic                       octave_down,
  input  logic                       start,
  input  logic                       stop,
  output logic                       salida,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(N_NOTES)-1:0] note_idx
);

  localparam int IDX_W = $clog2(N_NOTES);
  localparam int NUM_W = IDX_W + 1;
  localparam int HPE_W = HP_W + 1;
  localparam int CNT_W = (DUR_W > PAUSE_W) ? DUR_W : PAUSE_W;

  logic [HP_W-1:0]    tbl_hp  [N_NOTES];
  logic [DUR_W-1:0]   tbl_dur [N_NOTES];

  state_t             state, state_d;
  logic [NUM_W-1:0]   num_l;
  logic [3:0]         rep_l, play_cnt;
  logic [PAUSE_W-1:0] pause_l;
  logic [CNT_W-1:0]   cnt;
  logic [HPE_W-1:0]   hp_eff;
  logic [DUR_W-1:0]   dur_q;
  logic [HP_W-1:0]    cur_hp;
  logic [DUR_W-1:0]   cur_dur;
  logic               last_note, finish, advance, done_d;

  // Table is plain storage, writable at any time and never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tbl_hp[wr_addr]  <= wr_half_period;
      tbl_dur[wr_addr] <= wr_duration;
    end
  end

  assign cur_hp    = tbl_hp[note_idx];
  assign cur_dur   = tbl_dur[note_idx];
  assign last_note = ({1'b0, note_idx} >= num_l - NUM_W'(1));
  assign finish    = (rep_l != 4'd0) && (play_cnt + 4'd1 == rep_l);
  assign busy      = (state != IDLE);

  always_comb begin
    state_d = state;
    advance = 1'b0;
    case (state)
      IDLE:  if (start) state_d = LOAD;
      LOAD:  if (cur_dur == '0) advance = 1'b1;
             else state_d = TONE;
      TONE:  if (cnt == CNT_W'(dur_q) - CNT_W'(1)) advance = 1'b1;
      PAUSE: if (pause_l == '0 || cnt == CNT_W'(pause_l) - CNT_W'(1)) state_d = LOAD;
      default: state_d = IDLE;
    endcase
    if (advance) state_d = !last_note ? LOAD : (finish ? IDLE : PAUSE);
    // stop wins over start and over any advance in the same cycle.
    if (stop) begin
      state_d = IDLE;
      advance = 1'b0;
    end
    done_d = advance && last_note && finish;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      done     <= 1'b0;
      cnt      <= '0;
      num_l    <= '0;
      rep_l    <= '0;
      pause_l  <= '0;
      play_cnt <= '0;
      note_idx <= '0;
      hp_eff   <= '0;
      dur_q    <= '0;
    end else begin
      state <= state_d;
      done  <= done_d;
      cnt   <= (state_d != state || advance || state == IDLE) ? '0 : cnt + CNT_W'(1);
      if (state == IDLE && state_d == LOAD) begin
        if (num_notes == '0)                  num_l <= NUM_W'(1);
        else if (num_notes > NUM_W'(N_NOTES)) num_l <= NUM_W'(N_NOTES);
        else                                  num_l <= num_notes;
        rep_l    <= repeats;
        pause_l  <= pause_len;
        play_cnt <= '0;
        note_idx <= '0;
      end
      if (state == LOAD) begin
        hp_eff <= octave_down ? {cur_hp, 1'b0} : {1'b0, cur_hp};
        dur_q  <= cur_dur;
      end
      if (advance) begin
        if (!last_note) begin
          note_idx <= note_idx + IDX_W'(1);
        end else begin
          play_cnt <= play_cnt + 4'd1;
          if (!finish) note_idx <= '0;
        end
      end
    end
  end

  tono_gen #(.HPE_W(HPE_W)) u_tono (
    .clk    (clk),
    .rst_n  (rst_n),
    .hp_eff (hp_eff),
    .enable (state == TONE),
    .clear  (state != TONE),
    .salida (salida)
  );

endmodule
